// File: rtl/sd_block_prefetcher.sv
// Fetches a run of consecutive 512-byte SD blocks through the SPI block reader and streams them out of a FIFO.
// Optional feature macro SD_PREFETCH_CHECKSUM_EN adds a 16-bit running sum of the bytes popped in the current run.
module sd_block_prefetcher #(
   parameter int FIFO_DEPTH = 1024,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [22:0]      start_block,
   input  logic [CNT_W-1:0] num_blocks,
   output logic             busy,
   output logic             done,
   output logic             overrun,
   input  logic             rd_ready,
   output logic             rd_trigger,
   output logic [22:0]      rd_block_addr,
   input  logic [7:0]       rd_byte,
   input  logic             rd_byte_valid,
   output logic [7:0]       m_data,
   output logic             m_valid,
   input  logic             m_ready
`ifdef SD_PREFETCH_CHECKSUM_EN
   ,
   output logic [15:0]      checksum
`endif
);
   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] SPACE_MAX = (AW+1)'(FIFO_DEPTH - 512);

   typedef enum logic [2:0] {
      S_IDLE, S_SPACE, S_TRIG, S_RECV, S_WAITRDY, S_DRAIN, S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [AW:0]      count;
   logic             full, push, pop, accept, last_byte, low_seen;
   logic [CNT_W-1:0] blocks_left;
   logic [9:0]       byte_cnt;

   assign full       = (count == FULL_CNT);
   assign push       = rd_byte_valid && !full;
   assign m_valid    = (count != '0);
   assign pop        = m_valid && m_ready;
   assign rd_ptr_nxt = rd_ptr + AW'(pop);
   assign accept     = (state == S_IDLE) && start;
   assign last_byte  = (state == S_RECV) && rd_byte_valid && (byte_cnt == 10'd511);

   // NOTE: the byte storage has no reset; occupancy is tracked by count, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rd_byte;
   end

   // m_data always holds the head that will be current after this cycle; a push into an
   // otherwise empty FIFO bypasses the array so the first byte appears one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         m_data <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_ptr_nxt;
         count  <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (push && (count - (AW+1)'(pop)) == '0) m_data <= rd_byte;
         else                                      m_data <= mem[rd_ptr_nxt];
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      rd_trigger = 1'b0;
      unique case (state)
         S_IDLE:    if (start) state_nxt = (num_blocks == '0) ? S_DONE : S_SPACE;
         S_SPACE:   if (count <= SPACE_MAX && rd_ready) state_nxt = S_TRIG;
         S_TRIG: begin
            rd_trigger = 1'b1;
            state_nxt  = S_RECV;
         end
         S_RECV:    if (last_byte) state_nxt = (blocks_left == CNT_W'(1)) ? S_DRAIN : S_WAITRDY;
         S_WAITRDY: if (low_seen && rd_ready) state_nxt = S_SPACE;
         S_DRAIN:   if (count == '0) state_nxt = S_DONE;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         overrun       <= 1'b0;
         rd_block_addr <= '0;
         blocks_left   <= '0;
         byte_cnt      <= '0;
         low_seen      <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state == S_DONE);

         if (accept) begin
            busy          <= 1'b1;
            rd_block_addr <= start_block;
            blocks_left   <= num_blocks;
            overrun       <= 1'b0;
         end else if (state == S_DONE) begin
            busy <= 1'b0;
         end
         if (rd_byte_valid && full) overrun <= 1'b1;

         if (state == S_TRIG)                         byte_cnt <= '0;
         else if (state == S_RECV && rd_byte_valid)   byte_cnt <= byte_cnt + 10'd1;

         // The reader is still clocking CRC bytes after the 512th data byte; only a fresh
         // low-then-high on rd_ready means it can take the next trigger.
         if (last_byte) begin
            rd_block_addr <= rd_block_addr + 23'd1;
            blocks_left   <= blocks_left - CNT_W'(1);
            low_seen      <= 1'b0;
         end else if (state == S_WAITRDY && !rd_ready) begin
            low_seen <= 1'b1;
         end
      end
   end

`ifdef SD_PREFETCH_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      checksum <= '0;
      else if (accept) checksum <= '0;
      else if (pop)    checksum <= checksum + 16'(m_data);
   end
`endif

endmodule

// File: tb/tb_sd_block_prefetcher.sv
// Self-checking bench for sd_block_prefetcher: reader model, randomized consumer, run table and corner sequences.
module tb_sd_block_prefetcher;
   localparam int CNT_W = 16;

   logic             clk, rst_n, start;
   logic [22:0]      start_block;
   logic [CNT_W-1:0] num_blocks;
   logic             busy, done, overrun, rd_ready, rd_trigger, rd_byte_valid;
   logic [22:0]      rd_block_addr;
   logic [7:0]       rd_byte, m_data;
   logic             m_valid, m_ready;
`ifdef SD_PREFETCH_CHECKSUM_EN
   logic [15:0]      checksum;
`endif

   sd_block_prefetcher #(.FIFO_DEPTH(1024), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_block(start_block), .num_blocks(num_blocks),
      .busy(busy), .done(done), .overrun(overrun), .rd_ready(rd_ready), .rd_trigger(rd_trigger),
      .rd_block_addr(rd_block_addr), .rd_byte(rd_byte), .rd_byte_valid(rd_byte_valid),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef SD_PREFETCH_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   int checks = 0, failures = 0;
   int ready_mode = 0;      // 0: always ready, 1: random 50%, 2: hold off
   int salt = 0;
   int inject_req = 0;

   // Reader model state
   int rd_phase = 0, rd_idx = 0, rd_wait = 0, rd_crc = 0;
   int inject_done = 0, push_total = 0, bad_trig = 0;
   logic [22:0] rd_cur = '0;
   logic [22:0] trig_log[$];

   // Consumer side
   int pop_total = 0;
   logic [7:0] got[$];

   function automatic logic [7:0] blk_byte(input logic [22:0] a, input int idx, input int s);
      int v;
      v = idx + int'(a) * s;
      return v[7:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Block reader: drops rd_ready on trigger, emits 512 bytes with gaps, then 2 CRC cycles.
   initial begin
      rd_ready = 1'b1; rd_byte = '0; rd_byte_valid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rd_byte_valid = 1'b0;
         if (!rst_n) begin
            rd_phase = 0;
            rd_ready = 1'b1;
         end else begin
            if (rd_phase != 0 && rd_trigger) bad_trig++;
            case (rd_phase)
               0: begin
                  if (rd_trigger) begin
                     trig_log.push_back(rd_block_addr);
                     if (!rd_ready || (push_total - pop_total) > 512) bad_trig++;
                     rd_cur   = rd_block_addr;
                     rd_wait  = $urandom_range(0, 3);
                     rd_ready = 1'b0;
                     rd_phase = 1;
                  end else if (inject_done < inject_req) begin
                     rd_byte_valid = 1'b1;
                     rd_byte       = inject_done[7:0];
                     inject_done++;
                  end
               end
               1: begin
                  if (rd_wait == 0) begin rd_phase = 2; rd_idx = 0; end
                  else rd_wait--;
               end
               2: begin
                  if ($urandom_range(0, 3) != 0) begin
                     rd_byte_valid = 1'b1;
                     rd_byte       = blk_byte(rd_cur, rd_idx, salt);
                     rd_idx++;
                     push_total++;
                     if (rd_idx == 512) begin rd_phase = 3; rd_crc = 2; end
                  end
               end
               3: begin
                  rd_crc--;
                  if (rd_crc == 0) begin rd_ready = 1'b1; rd_phase = 0; end
               end
               default: rd_phase = 0;
            endcase
         end
      end
   end

   // Consumer: decides m_ready and records each transfer that the next edge will perform.
   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 1) == 1);
            default: m_ready = 1'b0;
         endcase
         if (rst_n && m_valid && m_ready) begin
            got.push_back(m_data);
            pop_total++;
         end
      end
   end

   task automatic start_run(input logic [22:0] sb, input logic [CNT_W-1:0] nb,
                            output int tbase, output int gbase);
      tbase = trig_log.size();
      gbase = got.size();
      start = 1'b1; start_block = sb; num_blocks = nb;
      tick();
      start = 1'b0;
      start_block = 23'($urandom);
      num_blocks  = CNT_W'($urandom);
   endtask

   task automatic wait_done(input int budget, output bit ok, output logic [15:0] ck);
      ok = 1'b0;
      ck = '0;
      for (int i = 0; i < budget; i++) begin
         if (done) begin
            ok = 1'b1;
`ifdef SD_PREFETCH_CHECKSUM_EN
            ck = checksum;
`endif
            check("busy_at_done", busy, 1'b0);
            break;
         end
         tick();
      end
   endtask

   // Reference: a run is blocks sb, sb+1, ... (23-bit wrap), each 512 bytes, delivered in order.
   task automatic check_run(input string name, input logic [22:0] sb, input int nb,
                            input int exp_trig, input int exp_bytes,
                            input int tbase, input int gbase, input bit ok, input logic [15:0] ck);
      logic [22:0] a;
      logic [7:0]  e;
      logic [15:0] sum;
      int tmism, bmism, k;
      tmism = 0; bmism = 0; sum = '0;
      check($sformatf("%s_done_seen", name), ok, 1'b1);
      check($sformatf("%s_trig_count", name), trig_log.size() - tbase, exp_trig);
      for (int b = 0; b < nb; b++) begin
         a = sb + 23'(b);
         if (tbase + b >= trig_log.size() || trig_log[tbase + b] !== a) tmism++;
         for (int i = 0; i < 512; i++) begin
            e   = blk_byte(a, i, salt);
            sum = sum + 16'(e);
            k   = gbase + b * 512 + i;
            if (k >= got.size() || got[k] !== e) bmism++;
         end
      end
      check($sformatf("%s_trig_addr_errs", name), tmism, 0);
      check($sformatf("%s_byte_count", name), got.size() - gbase, exp_bytes);
      check($sformatf("%s_byte_errs", name), bmism, 0);
      check($sformatf("%s_bad_trig", name), bad_trig, 0);
      check($sformatf("%s_overrun", name), overrun, 1'b0);
`ifdef SD_PREFETCH_CHECKSUM_EN
      check($sformatf("%s_checksum", name), ck, sum);
`else
      if (ck != '0) check($sformatf("%s_checksum_absent", name), ck, 16'h0);
`endif
   endtask

   typedef struct {
      logic [22:0]      sb;
      logic [CNT_W-1:0] nb;
      int               salt;
      int               mode;
      int               exp_trig;
      int               exp_bytes;
   } vec_t;

   initial begin
      vec_t vecs[6];
      int tbase, gbase, pbase, nb_r;
      bit ok;
      logic [15:0] ck;
      int emism;

      vecs[0] = '{23'h000100, 16'd1, 0, 0, 1, 512};      // single block, sequential data
      vecs[1] = '{23'h000200, 16'd4, 3, 1, 4, 2048};     // random consumer stalls
      vecs[2] = '{23'h7FFFFF, 16'd2, 5, 0, 2, 1024};     // address wraps to 0
      vecs[3] = '{23'h000050, 16'd0, 0, 0, 0, 0};        // empty run
      for (int i = 4; i < 6; i++) begin
         nb_r    = $urandom_range(1, 3);
         vecs[i] = '{23'($urandom), CNT_W'(nb_r), $urandom_range(1, 9), 1, nb_r, nb_r * 512};
      end

      rst_n = 1'b0; start = 1'b0; start_block = '0; num_blocks = '0;
      repeat (3) tick();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_trigger", rd_trigger, 1'b0);
      check("rst_addr", rd_block_addr, 23'h0);
      check("rst_m_valid", m_valid, 1'b0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         salt       = vecs[i].salt;
         ready_mode = vecs[i].mode;
         start_run(vecs[i].sb, vecs[i].nb, tbase, gbase);
         wait_done(20000, ok, ck);
         check_run($sformatf("vec%0d", i), vecs[i].sb, int'(vecs[i].nb),
                   vecs[i].exp_trig, vecs[i].exp_bytes, tbase, gbase, ok, ck);
`ifdef SD_PREFETCH_CHECKSUM_EN
         if (i == 0) check("vec0_checksum_const", ck, 16'hFF00);
`endif
         repeat (5) tick();
      end

      // Back-pressure: two blocks fill the FIFO, the third waits for 512 free entries.
      salt = 1; ready_mode = 2;
      start_run(23'h000100, 16'd3, tbase, gbase);
      pbase = push_total;
      for (int i = 0; i < 6000 && (push_total - pbase) < 1024; i++) tick();
      repeat (60) tick();
      check("bp_trig_held", trig_log.size() - tbase, 2);
      check("bp_m_valid", m_valid, 1'b1);
      check("bp_head", m_data, blk_byte(23'h000100, 0, 1));
      check("bp_overrun", overrun, 1'b0);
      ready_mode = 0;
      wait_done(20000, ok, ck);
      check_run("bp", 23'h000100, 3, 3, 1536, tbase, gbase, ok, ck);
      repeat (5) tick();

      // A second start during a run must be ignored.
      salt = 2; ready_mode = 1;
      start_run(23'h000300, 16'd3, tbase, gbase);
      repeat (700) tick();
      start = 1'b1; start_block = 23'h004444; num_blocks = 16'd9;
      tick();
      start = 1'b0;
      wait_done(20000, ok, ck);
      check_run("restart_ignored", 23'h000300, 3, 3, 1536, tbase, gbase, ok, ck);
      repeat (5) tick();

      // Push into a full FIFO while idle: excess bytes dropped, overrun sticks.
      ready_mode = 2;
      gbase = got.size();
      inject_req = 1030;
      for (int i = 0; i < 3000 && inject_done < inject_req; i++) tick();
      repeat (3) tick();
      check("ovr_flag", overrun, 1'b1);
      check("ovr_head", m_data, 8'h00);
      ready_mode = 0;
      for (int i = 0; i < 3000 && m_valid; i++) tick();
      check("ovr_pop_count", got.size() - gbase, 1024);
      emism = 0;
      for (int i = 0; i < 1024; i++) begin
         if (gbase + i >= got.size() || got[gbase + i] !== 8'(i)) emism++;
      end
      check("ovr_byte_errs", emism, 0);

      // Empty run: done one cycle after busy rises, overrun cleared by the start.
      tbase = trig_log.size();
      start = 1'b1; start_block = 23'h000777; num_blocks = '0;
      tick();
      start = 1'b0;
      check("zero_busy_up", busy, 1'b1);
      check("zero_done_early", done, 1'b0);
      check("zero_overrun_clr", overrun, 1'b0);
`ifdef SD_PREFETCH_CHECKSUM_EN
      check("zero_checksum_clr", checksum, 16'h0);
`endif
      tick();
      check("zero_done", done, 1'b1);
      check("zero_busy_down", busy, 1'b0);
      check("zero_m_valid", m_valid, 1'b0);
      tick();
      check("zero_done_pulse", done, 1'b0);
      check("zero_no_trig", trig_log.size() - tbase, 0);

      // Asynchronous reset in the middle of a block.
      salt = 4; ready_mode = 0;
      start_run(23'h000400, 16'd2, tbase, gbase);
      for (int i = 0; i < 3000 && !(rd_phase == 2 && rd_idx > 100); i++) tick();
      check("mid_in_recv", (rd_phase == 2), 1'b1);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_overrun", overrun, 1'b0);
      check("mid_rst_trigger", rd_trigger, 1'b0);
      check("mid_rst_addr", rd_block_addr, 23'h0);
      check("mid_rst_m_valid", m_valid, 1'b0);
`ifdef SD_PREFETCH_CHECKSUM_EN
      check("mid_rst_checksum", checksum, 16'h0);
`endif
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_m_valid", m_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
